// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime/mtimecmp plus msip on a valid/ready slave with one-cycle responses.
// Define CLINT_PRESCALE_EN to tick mtime every TIMEBASE_DIV clocks instead of every clock.
module clint_timer #(
  parameter int unsigned TIMEBASE_DIV = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        timer_irq,
  output logic        soft_irq,
  output logic [63:0] mtime
);

  localparam logic [13:0] A_MSIP    = 14'h0000;
  localparam logic [13:0] A_CMP_LO  = 14'h1000;
  localparam logic [13:0] A_CMP_HI  = 14'h1001;
  localparam logic [13:0] A_TIME_LO = 14'h2FFE;
  localparam logic [13:0] A_TIME_HI = 14'h2FFF;

  logic        req_ready_q;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        timer_irq_q;
  logic        tick;

  logic [13:0] word;
  logic        accept, wr, hit;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  assign word             = req_addr[15:2];
  assign unused_addr_bits = ^req_addr[1:0];
  assign accept           = req_valid && req_ready_q;
  assign wr               = accept && req_we;

  assign sel_msip    = (word == A_MSIP);
  assign sel_cmp_lo  = (word == A_CMP_LO);
  assign sel_cmp_hi  = (word == A_CMP_HI);
  assign sel_time_lo = (word == A_TIME_LO);
  assign sel_time_hi = (word == A_TIME_HI);
  assign hit         = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

`ifdef CLINT_PRESCALE_EN
  localparam int unsigned   PW      = (TIMEBASE_DIV > 1) ? $clog2(TIMEBASE_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TIMEBASE_DIV - 1);

  logic [PW-1:0] ps_q, ps_d;

  assign tick = (ps_q == PS_LAST);
  assign ps_d = tick ? '0 : ps_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ps_q <= '0;
    else        ps_q <= ps_d;
  end
`else
  // Every clock is a tick; an illegal zero divider parks the counter instead.
  assign tick = (TIMEBASE_DIV >= 1);
`endif

  // Reads see start-of-cycle values, so an mtime read in a tick cycle is pre-increment.
  always_comb begin
    rd_word = '0;
    if (sel_msip)         rd_word = {31'd0, msip_q};
    else if (sel_cmp_lo)  rd_word = mtimecmp_q[31:0];
    else if (sel_cmp_hi)  rd_word = mtimecmp_q[63:32];
    else if (sel_time_lo) rd_word = mtime_q[31:0];
    else if (sel_time_hi) rd_word = mtime_q[63:32];
  end

  assign rsp_valid_d = accept;
  assign rsp_err_d   = accept && !hit;
  assign rsp_rdata_d = (accept && !req_we) ? rd_word : 32'd0;

  // A bus write to either mtime half suppresses that cycle's tick for the whole counter.
  always_comb begin
    mtime_d = mtime_q;
    if (wr && (sel_time_lo || sel_time_hi)) begin
      if (sel_time_lo) mtime_d[31:0]  = merge_be(mtime_q[31:0],  req_wdata, req_be);
      if (sel_time_hi) mtime_d[63:32] = merge_be(mtime_q[63:32], req_wdata, req_be);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr && sel_cmp_lo) mtimecmp_d[31:0]  = merge_be(mtimecmp_q[31:0],  req_wdata, req_be);
    if (wr && sel_cmp_hi) mtimecmp_d[63:32] = merge_be(mtimecmp_q[63:32], req_wdata, req_be);
  end

  assign msip_d = (wr && sel_msip && req_be[0]) ? req_wdata[0] : msip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      timer_irq_q <= 1'b0;
    end else begin
      req_ready_q <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign timer_irq = timer_irq_q;
  assign soft_irq  = msip_q;
  assign mtime     = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed bus sequences, a per-cycle reference model, literal spot checks.
module tb_clint_timer;
  localparam int unsigned TB_DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err, timer_irq, soft_irq;
  logic [31:0] rsp_rdata;
  logic [63:0] mtime;

  int tests = 0;
  int fails = 0;

  clint_timer #(.TIMEBASE_DIV(TB_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .timer_irq(timer_irq), .soft_irq(soft_irq), .mtime(mtime)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state plus what the outputs must show after each edge.
  logic        m_ready, m_msip, e_vld, e_err, e_irq;
  logic [63:0] m_time, m_cmp, t0, c0;
  logic [31:0] e_rdata, m_rd;
  logic [15:0] aw;
  logic        acc, m_hit, tk, touched;
  int          m_ps;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 0; m_msip = 0; m_time = '0; m_cmp = '1; m_ps = 0;
      e_vld = 0; e_err = 0; e_irq = 0; e_rdata = '0;
    end else begin
      t0 = m_time; c0 = m_cmp;
      acc = req_valid && m_ready;
      aw  = req_addr & 16'hFFFC;
      m_hit = 1; m_rd = '0;
      case (aw)
        16'h0000: m_rd = {31'd0, m_msip};
        16'h4000: m_rd = c0[31:0];
        16'h4004: m_rd = c0[63:32];
        16'hBFF8: m_rd = t0[31:0];
        16'hBFFC: m_rd = t0[63:32];
        default:  m_hit = 0;
      endcase
      e_vld   = acc;
      e_err   = acc && !m_hit;
      e_rdata = (acc && !req_we) ? m_rd : 32'd0;
`ifdef CLINT_PRESCALE_EN
      tk   = (m_ps == int'(TB_DIV) - 1);
      m_ps = tk ? 0 : m_ps + 1;
`else
      tk = 1;
`endif
      touched = acc && req_we && (aw == 16'hBFF8 || aw == 16'hBFFC);
      if (acc && req_we) begin
        for (int b = 0; b < 4; b++) begin
          if (req_be[b]) begin
            case (aw)
              16'h0000: if (b == 0) m_msip = req_wdata[0];
              16'h4000: m_cmp[8*b +: 8]       = req_wdata[8*b +: 8];
              16'h4004: m_cmp[32 + 8*b +: 8]  = req_wdata[8*b +: 8];
              16'hBFF8: m_time[8*b +: 8]      = req_wdata[8*b +: 8];
              16'hBFFC: m_time[32 + 8*b +: 8] = req_wdata[8*b +: 8];
              default: ;
            endcase
          end
        end
      end
      if (!touched && tk) m_time = t0 + 64'd1;
      e_irq   = (t0 >= c0);
      m_ready = 1;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_req_ready", {63'd0, req_ready}, {63'd0, m_ready});
    chk("cyc_rsp_valid", {63'd0, rsp_valid}, {63'd0, e_vld});
    if (e_vld) begin
      chk("cyc_rsp_err", {63'd0, rsp_err}, {63'd0, e_err});
      chk("cyc_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e_rdata});
    end
    chk("cyc_mtime", mtime, m_time);
    chk("cyc_timer_irq", {63'd0, timer_irq}, {63'd0, e_irq});
    chk("cyc_soft_irq", {63'd0, soft_irq}, {63'd0, m_msip});
  end

  logic        r_vld, r_err;
  logic [31:0] r_data;

  task automatic bus(input logic we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    @(negedge clk);
    r_vld = rsp_valid; r_data = rsp_rdata; r_err = rsp_err;
    req_valid = 0;
  endtask

  task automatic idle(input int n);
    req_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [63:0] base;
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {63'd0, req_ready}, 64'd0);
    chk("reset_mtime", mtime, 64'd0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_rise", {63'd0, req_ready}, 64'd1);

    bus(0, 16'h4000, 0, 0);  chk("rd_cmp_lo", {32'd0, r_data}, 64'hFFFF_FFFF);
    bus(0, 16'h4004, 0, 0);  chk("rd_cmp_hi", {32'd0, r_data}, 64'hFFFF_FFFF);
    bus(0, 16'h0000, 0, 0);  chk("rd_msip_reset", {32'd0, r_data}, 64'd0);
    chk("irq_reset", {63'd0, timer_irq}, 64'd0);

    bus(1, 16'h4004, 32'd0, 4'hF);
    bus(1, 16'h4000, 32'd50, 4'hF);
    bus(1, 16'hBFF8, 32'd0, 4'hF);
    chk("wr_rsp", {31'd0, r_vld, r_err, r_data}, {31'd0, 1'b1, 1'b0, 32'd0});
    cnt = 0;
    while (timer_irq !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("irq_latency", 64'(cnt), 64'd51);
    bus(1, 16'h4000, 32'hFFFF_FFFF, 4'hF);
    chk("irq_hold", {63'd0, timer_irq}, 64'd1);
    idle(1);
    chk("irq_drop", {63'd0, timer_irq}, 64'd0);

    bus(1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    bus(1, 16'hBFFC, 32'd0, 4'hF);
    idle(2);
    bus(0, 16'hBFF8, 0, 0);  chk("carry_lo", {32'd0, r_data}, 64'd1);
    bus(0, 16'hBFFC, 0, 0);  chk("carry_hi", {32'd0, r_data}, 64'd1);
    bus(1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    bus(1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    chk("mtime_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    chk("mtime_wrap", mtime, 64'd0);

    bus(1, 16'h0000, 32'hFFFF_FFFF, 4'hF);
    chk("soft_set", {63'd0, soft_irq}, 64'd1);
    bus(0, 16'h0000, 0, 0);  chk("rd_msip", {32'd0, r_data}, 64'd1);
    bus(1, 16'h0003, 32'd0, 4'h0);
    chk("soft_be0", {63'd0, soft_irq}, 64'd1);

    bus(0, 16'h1000, 0, 0);
    chk("err_rsp", {31'd0, r_vld, r_err, r_data}, {31'd0, 1'b1, 1'b1, 32'd0});
    idle(1);
    chk("err_pulse", {63'd0, rsp_valid}, 64'd0);
    bus(1, 16'h1000, 32'h1234, 4'hF);
    chk("err_wr", {63'd0, r_err}, 64'd1);
    bus(1, 16'h4004, 32'hAABB_CCDD, 4'b0010);
    bus(0, 16'h4004, 0, 0);  chk("cmp_hi_byte", {32'd0, r_data}, 64'h0000_CC00);
    bus(1, 16'hBFF8, 32'h100, 4'hF);
    bus(0, 16'hBFF8, 0, 0);  chk("tick_wr_lo", {32'd0, r_data}, 64'h100);

    base = mtime;
    idle(100);
`ifdef CLINT_PRESCALE_EN
    chk("prescale_100", mtime - base, 64'(100 / TB_DIV));
`else
    chk("tick_100", mtime - base, 64'd100);
`endif

    req_valid = 1; req_we = 0; req_addr = 16'h0000; req_be = 4'h0;
    @(posedge clk);
    #2;
    req_valid = 0;
    rst_n = 0;
    #1;
    chk("midrst_rsp", {63'd0, rsp_valid}, 64'd0);
    chk("midrst_mtime", mtime, 64'd0);
    chk("midrst_flags", {61'd0, req_ready, timer_irq, soft_irq}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    bus(0, 16'h4000, 0, 0);  chk("midrst_cmp", {32'd0, r_data}, 64'hFFFF_FFFF);
    bus(0, 16'h0000, 0, 0);  chk("midrst_msip", {32'd0, r_data}, 64'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
